// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the BTB branch predictor.
// Holds the 2-bit counter encodings and their saturating update.
package bp_pkg;

    typedef logic [1:0] bp_cnt_t;

    localparam bp_cnt_t BP_SNT = 2'b00;
    localparam bp_cnt_t BP_WNT = 2'b01;
    localparam bp_cnt_t BP_WT  = 2'b10;
    localparam bp_cnt_t BP_ST  = 2'b11;

    function automatic bp_cnt_t bp_cnt_next(
        input bp_cnt_t cnt,
        input logic    taken
    );
        bp_cnt_t nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != BP_ST) nxt = cnt + 2'd1;
        end else begin
            if (cnt != BP_SNT) nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// IF lookup, EX resolve and statistics bundle of the predictor.
// master = core pipeline side, slave = predictor side.
interface bp_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  if_pc;
    logic             if_pred_taken;
    logic [XLEN-1:0]  if_pred_target;

    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic             ex_is_jump;
    logic             ex_taken;
    logic [XLEN-1:0]  ex_target;
    logic             ex_pred_taken;
    logic [XLEN-1:0]  ex_pred_target;
    logic             ex_redirect;
    logic [XLEN-1:0]  ex_redirect_pc;

    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_mispredicts;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_is_jump, ex_taken,
               ex_target, ex_pred_taken, ex_pred_target,
        input  if_pred_taken, if_pred_target, ex_redirect,
               ex_redirect_pc, stat_branches, stat_mispredicts
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_is_jump, ex_taken,
               ex_target, ex_pred_taken, ex_pred_target,
        output if_pred_taken, if_pred_target, ex_redirect,
               ex_redirect_pc, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Saturating event counter used for predictor statistics.
// Sticks at all-ones instead of wrapping.
module bp_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: IF lookup, EX resolve/update.
// Lookup reads stored state only, so same-cycle updates are not bypassed.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = XLEN - $clog2(ENTRIES) - 2,
    parameter int CNT_W   = 32
) (
    input  logic cpu_clk,
    input  logic cpu_rst,
    bp_if.slave  bp
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] valid_q;
    bp_cnt_t            cnt_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [XLEN-1:0]    tgt_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic             lk_hit;
    logic [IDX_W-1:0] ex_idx;
    logic             ex_hit;

    logic    alloc;
    logic    cnt_we;
    logic    tgt_we;
    bp_cnt_t cnt_d;

    assign lk_idx = bp.if_pc[IDX_W+1:2];
    assign lk_hit = valid_q[lk_idx] &&
                    (tag_q[lk_idx] == bp.if_pc[IDX_W+2 +: TAG_W]);

    assign bp.if_pred_taken  = lk_hit && cnt_q[lk_idx][1];
    assign bp.if_pred_target = bp.if_pred_taken ? tgt_q[lk_idx]
                                                : bp.if_pc + XLEN'(4);

    always_comb begin
        bp.ex_redirect = 1'b0;
        if (bp.ex_valid) begin
            bp.ex_redirect = (bp.ex_pred_taken != bp.ex_taken) ||
                             (bp.ex_taken &&
                              (bp.ex_pred_target != bp.ex_target));
        end
    end

    assign bp.ex_redirect_pc = bp.ex_taken ? bp.ex_target
                                           : bp.ex_pc + XLEN'(4);

    assign ex_idx = bp.ex_pc[IDX_W+1:2];
    assign ex_hit = valid_q[ex_idx] &&
                    (tag_q[ex_idx] == bp.ex_pc[IDX_W+2 +: TAG_W]);

    always_comb begin
        alloc  = bp.ex_valid && !ex_hit && bp.ex_taken;
        cnt_we = bp.ex_valid && (ex_hit || bp.ex_taken);
        tgt_we = bp.ex_valid &&
                 (bp.ex_taken || (ex_hit && bp.ex_is_jump));
        cnt_d  = BP_WT;
        if (bp.ex_is_jump) cnt_d = BP_ST;
        else if (ex_hit)   cnt_d = bp_cnt_next(cnt_q[ex_idx], bp.ex_taken);
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= BP_WNT;
            end
        end else begin
            if (cnt_we) cnt_q[ex_idx]   <= cnt_d;
            if (alloc)  valid_q[ex_idx] <= 1'b1;
        end
    end

    // Tags/targets need no reset; valid gates them. Reset still blocks writes.
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst) begin
            if (alloc)  tag_q[ex_idx] <= bp.ex_pc[IDX_W+2 +: TAG_W];
            if (tgt_we) tgt_q[ex_idx] <= bp.ex_target;
        end
    end

    bp_sat_counter #(.W(CNT_W)) u_stat_br (
        .clk_i (cpu_clk),
        .rst_i (cpu_rst),
        .inc_i (bp.ex_valid),
        .cnt_o (bp.stat_branches)
    );

    bp_sat_counter #(.W(CNT_W)) u_stat_mp (
        .clk_i (cpu_clk),
        .rst_i (cpu_rst),
        .inc_i (bp.ex_redirect),
        .cnt_o (bp.stat_mispredicts)
    );
endmodule
